// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the coordinate type used by renderers.
package vga_pkg;

  localparam int unsigned COORD_W = 10;

  typedef logic [COORD_W-1:0] coord_t;

  localparam int unsigned VGA_H_VISIBLE = 640;
  localparam int unsigned VGA_H_FP      = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BP      = 48;
  localparam int unsigned VGA_V_VISIBLE = 480;
  localparam int unsigned VGA_V_FP      = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BP      = 33;

  localparam int unsigned VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

endpackage

// File: rtl/vga_mod_counter.sv
// Modulo-N up-counter with enable, synchronous reset and a terminal-count flag.
module vga_mod_counter #(
  parameter int unsigned N = 800,
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count,
  output logic [W-1:0] count_nxt_c,
  output logic         wrap
);

  assign wrap = (count == W'(N - 1));

  // Next value is exported so the parent can register flags for the same position.
  always_comb begin
    count_nxt_c = count;
    if (reset) begin
      count_nxt_c = '0;
    end else if (en) begin
      count_nxt_c = wrap ? '0 : count + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_nxt_c;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster position, blank and sync generator.
// Optional macro VGA_SYNC_ALIGN_EN delays hs/vs one pixel to match registered RGB.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
  parameter int unsigned H_FP      = VGA_H_FP,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BP      = VGA_H_BP,
  parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
  parameter int unsigned V_FP      = VGA_V_FP,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BP      = VGA_V_BP
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       pix_en,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_VIS_END = coord_t'(H_VISIBLE);
  localparam coord_t HS_START  = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t HS_END    = coord_t'(H_VISIBLE + H_FP + H_SYNC);
  localparam coord_t V_VIS_END = coord_t'(V_VISIBLE);
  localparam coord_t VS_START  = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t VS_END    = coord_t'(V_VISIBLE + V_FP + V_SYNC);

  coord_t x_q, y_q, x_nxt, y_nxt;
  logic   h_wrap, v_wrap, v_en;
  logic   blank_nxt, hs_nxt, vs_nxt, fs_nxt;
  logic   blank_q, hs_q, vs_q, fs_q;

  assign v_en = h_wrap & pix_en;

  vga_mod_counter #(.N(H_TOTAL), .W(COORD_W)) u_h_cnt (
    .clk        (vga_clk),
    .reset      (reset),
    .en         (pix_en),
    .count      (x_q),
    .count_nxt_c(x_nxt),
    .wrap       (h_wrap)
  );

  vga_mod_counter #(.N(V_TOTAL), .W(COORD_W)) u_v_cnt (
    .clk        (vga_clk),
    .reset      (reset),
    .en         (v_en),
    .count      (y_q),
    .count_nxt_c(y_nxt),
    .wrap       (v_wrap)
  );

  // Flags decoded from the next position so they land in the same cycle as it.
  always_comb begin
    blank_nxt = (x_nxt < H_VIS_END) && (y_nxt < V_VIS_END);
    hs_nxt    = !((x_nxt >= HS_START) && (x_nxt < HS_END));
    vs_nxt    = !((y_nxt >= VS_START) && (y_nxt < VS_END));
    fs_nxt    = fs_q;
    if (reset) begin
      fs_nxt = 1'b1;
    end else if (pix_en) begin
      fs_nxt = h_wrap & v_wrap;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      blank_q <= 1'b1;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      fs_q    <= 1'b1;
    end else begin
      blank_q <= blank_nxt;
      hs_q    <= hs_nxt;
      vs_q    <= vs_nxt;
      fs_q    <= fs_nxt;
    end
  end

`ifdef VGA_SYNC_ALIGN_EN
  logic hs_dly_q, vs_dly_q;

  // Extra pixel of sync delay to match the renderer's registered colour.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hs_dly_q <= 1'b1;
      vs_dly_q <= 1'b1;
    end else if (pix_en) begin
      hs_dly_q <= hs_q;
      vs_dly_q <= vs_q;
    end
  end

  assign hs = hs_dly_q;
  assign vs = vs_dly_q;
`else
  assign hs = hs_q;
  assign vs = vs_q;
`endif

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign blank       = blank_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full-size line timing plus a shrunken instance for frame timing.
module tb_vga_timing_gen;

`ifdef VGA_SYNC_ALIGN_EN
  localparam int SYNC_SHIFT = 1;
`else
  localparam int SYNC_SHIFT = 0;
`endif

  logic       vga_clk;
  logic       reset;
  logic       pix_en;
  logic [9:0] dx, dy, sx, sy;
  logic       bl, hs, vs, fs;
  logic       sbl, shs, svs, sfs;

  int tests  = 0;
  int failed = 0;

  vga_timing_gen u_dut (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .pix_en     (pix_en),
    .DrawX      (dx),
    .DrawY      (dy),
    .blank      (bl),
    .hs         (hs),
    .vs         (vs),
    .frame_start(fs)
  );

  // Small raster: 15 x 9 total, hs low x 10..12, vs low y 5..6, 135-cycle frame.
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) u_small (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .pix_en     (pix_en),
    .DrawX      (sx),
    .DrawY      (sy),
    .blank      (sbl),
    .hs         (shs),
    .vs         (svs),
    .frame_start(sfs)
  );

  initial begin
    vga_clk = 1'b0;
    forever #5 vga_clk = ~vga_clk;
  end

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int hs_cnt, hs_first, hs_last, bl_fall, dy_bad, cyc, bad_hold, bad_adv;
    int vs_cnt, vs_fx, vs_fy, bl_cnt, fs_cnt;
    logic [9:0]  prev_x;
    logic [23:0] snap;

    reset  = 1'b1;
    pix_en = 1'b1;
    repeat (3) step();
    check("rst_x", dx, 0);
    check("rst_y", dy, 0);
    check("rst_blank", bl, 1);
    check("rst_hs", hs, 1);
    check("rst_vs", vs, 1);
    check("rst_fs", fs, 1);
    check("rst_small_pos", {sx, sy}, 0);

    reset = 1'b0;
    step();
    check("first_x", dx, 1);
    check("first_fs", fs, 0);

    // One line at full rate.
    hs_cnt = 0; hs_first = -1; hs_last = -1; bl_fall = -1; dy_bad = 0;
    for (int i = 0; i < 2000 && dx != 10'd799; i++) begin
      step();
      if (!hs) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(dx);
        hs_last = int'(dx);
      end
      if (!bl && bl_fall < 0) bl_fall = int'(dx);
      if (dy != 10'd0) dy_bad++;
    end
    check("line_end_x", dx, 799);
    check("blank_fall_x", bl_fall, 640);
    check("hs_width", hs_cnt, 96);
    check("hs_first_x", hs_first, 656 + SYNC_SHIFT);
    check("hs_last_x", hs_last, 751 + SYNC_SHIFT);
    check("line_dy_const", dy_bad, 0);
    step();
    check("hwrap_x", dx, 0);
    check("hwrap_y", dy, 1);
    check("hwrap_blank", bl, 1);

    // Half-rate line: pix_en 0,1,0,1...
    cyc = 0; bad_hold = 0; bad_adv = 0;
    while (!(dx == 10'd0 && dy == 10'd2) && cyc < 4000) begin
      pix_en = (cyc % 2) == 1;
      snap   = {dx, dy, bl, hs, vs, fs};
      prev_x = dx;
      step();
      cyc++;
      if (!pix_en && ({dx, dy, bl, hs, vs, fs} !== snap)) bad_hold++;
      if (pix_en && dx !== ((prev_x == 10'd799) ? 10'd0 : prev_x + 10'd1)) bad_adv++;
    end
    check("halfrate_cycles", cyc, 1600);
    check("halfrate_hold", bad_hold, 0);
    check("halfrate_adv", bad_adv, 0);

    // Reset mid-line.
    pix_en = 1'b1;
    repeat (300) step();
    check("mid_pos", {dx, dy}, {10'd300, 10'd2});
    reset = 1'b1;
    step();
    check("midrst_pos", {dx, dy}, 0);
    check("midrst_flags", {bl, hs, vs, fs}, 4'b1111);
    reset = 1'b0;
    repeat (700) step();
    check("hs_active_700", hs, 0);
    reset  = 1'b1;
    pix_en = 1'b0;
    step();
    check("rst_over_en_x", dx, 0);
    check("rst_cuts_hs", hs, 1);

    // Full frame on the small instance.
    pix_en = 1'b1;
    step();
    reset = 1'b0;
    cyc = 0; vs_cnt = 0; vs_fx = -1; vs_fy = -1; bl_cnt = 0; fs_cnt = 0;
    do begin
      step();
      cyc++;
      if (!svs) begin
        vs_cnt++;
        if (vs_fy < 0) begin
          vs_fx = int'(sx);
          vs_fy = int'(sy);
        end
      end
      if (sbl) bl_cnt++;
      if (sfs) fs_cnt++;
    end while (!(sx == 10'd0 && sy == 10'd0) && cyc < 1000);
    check("frame_period", cyc, 135);
    check("vs_width", vs_cnt, 30);
    check("vs_first_x", vs_fx, SYNC_SHIFT);
    check("vs_first_y", vs_fy, 5);
    check("visible_px", bl_cnt, 32);
    check("fs_once", fs_cnt, 1);
    check("fwrap_fs", sfs, 1);

    // Reset in the middle of a vsync pulse.
    for (int i = 0; i < 500 && !(sx == 10'd3 && sy == 10'd5); i++) step();
    check("small_pos_in_vs", {sx, sy}, {10'd3, 10'd5});
    check("small_vs_low", svs, 0);
    reset = 1'b1;
    step();
    check("vsrst_pos", {sx, sy}, 0);
    check("vsrst_vs", svs, 1);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Pixel-timing generator driving the 640x480 @ 60 Hz VGA output; it produces the raster scan position `DrawX`/`DrawY`, the active-video flag `blank`, and the sync pulses. Sprite/ROM renderers take `DrawX`, `DrawY` and `blank` and return 4-bit RGB one `vga_clk` later. This block is the source end of that pixel interface and sits between the clock wizard and every renderer plus the VGA/HDMI encoder.

## Interface
- `H_VISIBLE`, 640, active pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_VISIBLE`, 480, active lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BP`, 33, vertical back porch (lines)

Ports:
- `vga_clk`  in  1  pixel clock (25 MHz nominal); all logic on posedge
- `reset`  in  1  synchronous, active-high reset
- `pix_en`  in  1  advance enable; counters step only when high (tie to 1 for full rate)
- `DrawX`  out  10  horizontal position, 0..H_TOTAL-1
- `DrawY`  out  10  vertical position, 0..V_TOTAL-1
- `blank`  out  1  1 = visible region (renderer drives colour), 0 = blanking
- `hs`  out  1  horizontal sync, active-low
- `vs`  out  1  vertical sync, active-low
- `frame_start`  out  1  high while DrawX==0 && DrawY==0

## Operation
- H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525). All compares are unsigned and 10 bits wide; totals must be ≤ 1024.
- Horizontal counter: on `pix_en`, DrawX+1; at H_TOTAL-1 it wraps to 0 and DrawY steps.
- Vertical counter: steps only on horizontal wrap; at V_TOTAL-1 it wraps to 0. The simultaneous wrap (799,524) goes to (0,0) on one edge.
- `blank` = (DrawX < H_VISIBLE) && (DrawY < V_VISIBLE).
- `hs` = 0 iff H_VISIBLE+H_FP ≤ DrawX < H_VISIBLE+H_FP+H_SYNC (656..751).
- `vs` = 0 iff V_VISIBLE+V_FP ≤ DrawY < V_VISIBLE+V_FP+V_SYNC (490..491).
- All flags are registered. They are computed from the next counter value, so every output refers to the same DrawX/DrawY in the same cycle. No combinational path runs from an input to an output.
- `pix_en`=0: every output holds its value.
- `reset` outranks `pix_en`.

## Timing
- Reset values (cycle after `reset` sampled high): DrawX=0, DrawY=0, blank=1, hs=1, vs=1, frame_start=1.
- Reset mid-frame: the next edge forces (0,0), and the scan restarts from there.
- Latency: zero cycles between the counter value and its flags.
- Period with pix_en=1: 800 cycles per line, 420000 cycles per frame.
- Renderer contract: RGB for (DrawX,DrawY) is valid one cycle later; sync alignment for that delay is handled under Configuration.

## Configuration
- `VGA_SYNC_ALIGN_EN` defined: `hs` and `vs` pass through one extra `pix_en`-qualified register stage, so they line up with the renderer's registered RGB. DrawX, DrawY, blank and frame_start are unchanged. Reset value of the delay stage is 1.
- Undefined: `hs`/`vs` are aligned with DrawX/DrawY as specified under Operation.

## Structure
- Package `vga_pkg` holds:
  - the default timing constants and derived H_TOTAL/V_TOTAL as localparams;
  - the 10-bit `coord_t` typedef used for DrawX/DrawY by renderers.
- One sub-module, `vga_mod_counter`: a parameterised modulo-N counter with enable, synchronous reset and a `wrap` output. It is instantiated twice; the horizontal `wrap` ANDed with `pix_en` drives the vertical enable.

## Test plan
- Reset held 3 cycles, then released with pix_en=1 -> DrawX=0, DrawY=0, blank=1, hs=1, vs=1, frame_start=1 on the first post-reset cycle; DrawX=1 and frame_start=0 on the next.
- Run 1 line -> blank falls when DrawX=640; hs=0 exactly for DrawX 656..751 (96 cycles); DrawX 799 -> 0 with DrawY 0 -> 1.
- Run 1 full frame -> vs=0 for DrawY 490..491 only (1600 cycles); (799,524) -> (0,0) with frame_start=1; period is 420000 cycles.
- Drive pix_en=1,0 alternating -> DrawX advances every second cycle, all outputs are stable while pix_en=0, and the line takes 1600 cycles.
- Assert reset at (300,200) -> next cycle shows (0,0) with reset values; no partial hs/vs pulse is emitted.
- With `VGA_SYNC_ALIGN_EN` defined -> hs falls one cycle after DrawX=656 and rises one cycle after DrawX=752; blank timing is unchanged.
